// File: rtl/fifo_noc2nic_if.sv
// fifo_noc2nic_if: router-side flit/credit bundle and consumer-side handshake for fifo_noc2nic
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
interface fifo_noc2nic_if #(parameter int N_TOT_OF_VC = 6);
  logic [`FLIT_WIDTH-1:0] in_link_i;
  logic is_valid_i;
  logic [N_TOT_OF_VC-1:0] credit_signal_o;
  logic [N_TOT_OF_VC-1:0] free_signal_o;
  logic [`FLIT_WIDTH-1:0] out_flit_o;
  logic out_valid_o;
  logic [N_TOT_OF_VC-1:0] out_vc_o;
  logic ready_i;
  logic overflow_o;
  modport master (
    output in_link_i, is_valid_i, ready_i,
    input credit_signal_o, free_signal_o, out_flit_o, out_valid_o, out_vc_o, overflow_o
  );
  modport slave (
    input in_link_i, is_valid_i, ready_i,
    output credit_signal_o, free_signal_o, out_flit_o, out_valid_o, out_vc_o, overflow_o
  );
endinterface

// File: rtl/fifo_noc2nic.sv
// fifo_noc2nic: per-VC flit FIFOs with packet-locking round-robin drain; define FIFO_NOC2NIC_OVF_CHECK_EN for a sticky overflow flag
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
module fifo_noc2nic #(
  parameter int N_TOT_OF_VC = 6,
  parameter int N_BITS_VC = 3,
  parameter int N_FIFO_DEPTH = 4,
  parameter int N_BITS_DEPTH = 2,
  parameter int VC_ID_LSB = 0,
  parameter int FLIT_TYPE_LSB = 3
) (
  input logic clk,
  input logic rst,
  fifo_noc2nic_if.slave bus
);
  localparam int W = `FLIT_WIDTH;
  localparam logic [N_BITS_DEPTH:0] FULL = (N_BITS_DEPTH+1)'(N_FIFO_DEPTH);
  localparam logic [N_BITS_VC:0] NV = (N_BITS_VC+1)'(N_TOT_OF_VC);
  localparam logic [N_TOT_OF_VC-1:0] ONE = N_TOT_OF_VC'(1);
  typedef enum logic {IDLE, LOCKED} state_t;
  logic [W-1:0] mem [N_TOT_OF_VC][N_FIFO_DEPTH];
  logic [N_BITS_DEPTH-1:0] wp [N_TOT_OF_VC];
  logic [N_BITS_DEPTH-1:0] rp [N_TOT_OF_VC];
  logic [N_BITS_DEPTH:0] cnt [N_TOT_OF_VC];
  state_t state, state_n;
  logic [N_BITS_VC-1:0] rr_r, rr_n, lock_r, lock_n, gnt, push_vc;
  logic [N_BITS_VC:0] idx, nxt;
  logic [N_TOT_OF_VC-1:0] nonempty, push_oh, pop_oh, credit_r, free_r;
  logic [W-1:0] head;
  logic [1:0] ftype;
  logic found, pop, push_ok;
  // per-VC occupancy flags and push qualification on pre-edge fullness
  always_comb begin
    nonempty = '0;
    for (int i = 0; i < N_TOT_OF_VC; i++) nonempty[i] = cnt[i] != '0;
    push_vc = bus.in_link_i[VC_ID_LSB +: N_BITS_VC];
    push_ok = bus.is_valid_i && ({1'b0, push_vc} < NV) && (cnt[push_vc] != FULL);
    push_oh = push_ok ? ONE << push_vc : '0;
  end
  // grant: locked VC, else first non-empty VC scanning up from rr_r with wrap
  always_comb begin
    found = 1'b0;
    gnt = lock_r;
    idx = '0;
    if (state == LOCKED) found = nonempty[lock_r];
    else
      for (int i = 0; i < N_TOT_OF_VC; i++) begin
        idx = {1'b0, rr_r} + (N_BITS_VC+1)'(i);
        if (idx >= NV) idx = idx - NV;
        if (!found && nonempty[idx[N_BITS_VC-1:0]]) begin
          found = 1'b1;
          gnt = idx[N_BITS_VC-1:0];
        end
      end
    head = mem[gnt][rp[gnt]];
    ftype = head[FLIT_TYPE_LSB +: 2];
    pop = found && bus.ready_i;
    pop_oh = pop ? ONE << gnt : '0;
    nxt = ({1'b0, gnt} + (N_BITS_VC+1)'(1) >= NV) ? '0 : {1'b0, gnt} + (N_BITS_VC+1)'(1);
  end
  // arbiter next state: head locks, tail/head-tail releases and advances rr_r
  always_comb begin
    state_n = state;
    rr_n = rr_r;
    lock_n = lock_r;
    if (pop && ftype[1]) begin
      state_n = IDLE;
      rr_n = nxt[N_BITS_VC-1:0];
    end else if (pop && ftype == 2'b01) begin
      state_n = LOCKED;
      lock_n = gnt;
    end
  end
  // arbiter state and one-cycle credit/free pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_r <= '0;
      lock_r <= '0;
      credit_r <= '0;
      free_r <= '0;
    end else begin
      state <= state_n;
      rr_r <= rr_n;
      lock_r <= lock_n;
      credit_r <= pop_oh;
      free_r <= (pop && ftype[1]) ? pop_oh : '0;
    end
  end
  // per-VC pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
        wp[v] <= '0;
        rp[v] <= '0;
        cnt[v] <= '0;
      end
    end else begin
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
        wp[v] <= wp[v] + N_BITS_DEPTH'(push_oh[v]);
        rp[v] <= rp[v] + N_BITS_DEPTH'(pop_oh[v]);
        cnt[v] <= cnt[v] + (N_BITS_DEPTH+1)'(push_oh[v]) - (N_BITS_DEPTH+1)'(pop_oh[v]);
      end
    end
  end
  // flit storage, written at the tail of the addressed VC
  always_ff @(posedge clk) begin
    for (int v = 0; v < N_TOT_OF_VC; v++)
      if (push_oh[v]) mem[v][wp[v]] <= bus.in_link_i;
  end
`ifdef FIFO_NOC2NIC_OVF_CHECK_EN
  logic ovf_r;
  // sticky flag for any valid flit that could not be stored
  always_ff @(posedge clk) begin
    if (rst) ovf_r <= 1'b0;
    else if (bus.is_valid_i && !push_ok) ovf_r <= 1'b1;
  end
  assign bus.overflow_o = ovf_r;
`else
  assign bus.overflow_o = 1'b0;
`endif
  assign bus.out_valid_o = found;
  assign bus.out_vc_o = found ? ONE << gnt : '0;
  assign bus.out_flit_o = found ? head : '0;
  assign bus.credit_signal_o = credit_r;
  assign bus.free_signal_o = free_r;
endmodule

// File: tb/tb_fifo_noc2nic.sv
// tb_fifo_noc2nic: queue-based reference model plus directed scenarios and random traffic
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
module tb_fifo_noc2nic;
  localparam int W = `FLIT_WIDTH;
`ifdef FIFO_NOC2NIC_OVF_CHECK_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_noc2nic_if #(.N_TOT_OF_VC(6)) bus();
  fifo_noc2nic dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int tests = 0;
  int fails = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [W-1:0] mk(input int t, input int vc, input int p);
    return {p[W-6:0], t[1:0], vc[2:0]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [W-1:0] f, input logic r);
    bus.is_valid_i = v;
    bus.in_link_i = f;
    bus.ready_i = r;
  endtask
  task automatic rst_pulse();
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  logic [W-1:0] q [6][$];
  int lk = -1;
  int rr = 0;
  logic [5:0] ecr = '0;
  logic [5:0] efr = '0;
  logic eov = 1'b0;
  bit armed = 1'b0;
  // reference model: expected outputs from queues, then advance by one edge
  always @(negedge clk) begin : model
    bit v, ok;
    int g, vc;
    logic [W-1:0] h;
    v = 1'b0;
    g = 0;
    h = '0;
    if (lk >= 0) begin
      g = lk;
      v = q[lk].size() > 0;
    end else
      for (int i = 0; i < 6; i++)
        if (!v && q[(rr+i)%6].size() > 0) begin
          v = 1'b1;
          g = (rr + i) % 6;
        end
    if (v) h = q[g][0];
    if (armed) begin
      chk("out_valid", 32'(bus.out_valid_o), 32'(v));
      chk("out_vc", 32'(bus.out_vc_o), v ? 32'(1) << g : 32'(0));
      chk("out_flit", 32'(bus.out_flit_o), 32'(h));
      chk("credit", 32'(bus.credit_signal_o), 32'(ecr));
      chk("free", 32'(bus.free_signal_o), 32'(efr));
      chk("overflow", 32'(bus.overflow_o), 32'(eov));
    end
    if (rst) begin
      foreach (q[i]) q[i].delete();
      lk = -1;
      rr = 0;
      ecr = '0;
      efr = '0;
      eov = 1'b0;
      armed = 1'b1;
    end else begin
      vc = int'(bus.in_link_i[2:0]);
      ok = 1'b0;
      if (bus.is_valid_i && vc < 6) ok = q[vc].size() < 4;
      if (bus.is_valid_i && !ok && OVF) eov = 1'b1;
      ecr = '0;
      efr = '0;
      if (v && bus.ready_i) begin
        h = q[g].pop_front();
        ecr = 6'(1) << g;
        if (h[4]) begin
          efr = ecr;
          lk = -1;
          rr = (g + 1) % 6;
        end else if (h[4:3] == 2'b01) lk = g;
      end
      if (ok) q[vc].push_back(bus.in_link_i);
    end
  end
  initial begin
    int n, thr;
    logic [W-1:0] f;
    drive(1'b0, '0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    // single head-tail packet on VC2
    drive(1'b1, mk(3, 2, 1), 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    chk("r20_valid", 32'(bus.out_valid_o), 32'd1);
    chk("r20_vc", 32'(bus.out_vc_o), 32'b000100);
    tick();
    chk("r20_credit", 32'(bus.credit_signal_o), 32'b000100);
    chk("r20_free", 32'(bus.free_signal_o), 32'b000100);
    tick();
    chk("r20_credit_end", 32'(bus.credit_signal_o), 32'd0);
    chk("r20_free_end", 32'(bus.free_signal_o), 32'd0);
    // VC1 packet holds the grant against a waiting VC0 head-tail
    rst_pulse();
    drive(1'b1, mk(1, 1, 2), 1'b1);
    tick();
    drive(1'b1, mk(3, 0, 3), 1'b1);
    tick();
    drive(1'b1, mk(0, 1, 4), 1'b1);
    chk("r21_lock_hold", 32'(bus.out_valid_o), 32'd0);
    tick();
    drive(1'b1, mk(2, 1, 5), 1'b1);
    chk("r21_body_vc", 32'(bus.out_vc_o), 32'b000010);
    tick();
    drive(1'b0, '0, 1'b1);
    chk("r21_tail_vc", 32'(bus.out_vc_o), 32'b000010);
    tick();
    chk("r21_next_vc0", 32'(bus.out_vc_o), 32'b000001);
    chk("r21_free_vc1", 32'(bus.free_signal_o), 32'b000010);
    tick();
    // five pushes to a depth-4 VC
    rst_pulse();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(0, 3, 10 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    chk("r22_ovf", 32'(bus.overflow_o), 32'(OVF));
    drive(1'b0, '0, 1'b1);
    n = 0;
    repeat (8) begin
      tick();
      if (bus.credit_signal_o[3]) n++;
    end
    chk("r22_credits", n, 32'd4);
    // push and pop on a full VC in one cycle
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(0, 3, 20 + i), 1'b0);
      tick();
    end
    drive(1'b1, mk(0, 3, 30), 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    n = 0;
    repeat (8) begin
      tick();
      if (bus.credit_signal_o[3]) n++;
    end
    chk("r23_remaining", n, 32'd3);
    // reset while VC4 is locked with two flits queued
    rst_pulse();
    drive(1'b1, mk(1, 4, 40), 1'b1);
    tick();
    drive(1'b1, mk(0, 4, 41), 1'b1);
    tick();
    drive(1'b1, mk(0, 4, 42), 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    chk("r24_valid", 32'(bus.out_valid_o), 32'd0);
    chk("r24_vc", 32'(bus.out_vc_o), 32'd0);
    chk("r24_credit", 32'(bus.credit_signal_o), 32'd0);
    chk("r24_free", 32'(bus.free_signal_o), 32'd0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b1);
    tick();
    chk("r24_post_credit", 32'(bus.credit_signal_o), 32'd0);
    chk("r24_post_valid", 32'(bus.out_valid_o), 32'd0);
    // backpressure on VC5
    rst_pulse();
    f = mk(0, 5, 77);
    drive(1'b1, f, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    repeat (10) begin
      chk("r25_flit", 32'(bus.out_flit_o), 32'(f));
      chk("r25_no_credit", 32'(bus.credit_signal_o), 32'd0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    tick();
    chk("r25_credit", 32'(bus.credit_signal_o), 32'b100000);
    // random traffic with bad VC ids and occasional resets
    rst_pulse();
    thr = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) thr = $urandom_range(0, 3);
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 2) != 0,
            mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom)),
            $urandom_range(0, 3) < thr + 1);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b1);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_noc2nic.md
FIFO_NOC2NIC -- requirements
Module: fifo_noc2nic

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- N_TOT_OF_VC, 6, total VCs (`N_OF_VC*`N_OF_VN).
- N_BITS_VC, 3, clog2(N_TOT_OF_VC).
- N_FIFO_DEPTH, 4, flits per VC buffer (power of two, >=2).
- N_BITS_DEPTH, 2, clog2(N_FIFO_DEPTH).
- VC_ID_LSB, 0, LSB of the VC-id field (N_BITS_VC wide) in the flit.
- FLIT_TYPE_LSB, 3, LSB of the 2-bit type field (00 body, 01 head, 10 tail, 11 head-tail).

REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock.
- rst, in, 1, reset: synchronous and active-high.
- in_link_i, in, `FLIT_WIDTH, flit from the router.
- is_valid_i, in, 1, in_link_i valid this cycle.
- credit_signal_o, out, N_TOT_OF_VC, one-cycle credit return per VC.
- free_signal_o, out, N_TOT_OF_VC, one-cycle VC-free pulse per VC.
- out_flit_o, out, `FLIT_WIDTH, head flit of the granted VC.
- out_valid_o, out, 1, out_flit_o valid.
- out_vc_o, out, N_TOT_OF_VC, one-hot granted VC.
- ready_i, in, 1, consumer accepts out_flit_o.
- overflow_o, out, 1, sticky overflow error.

Function
REQ-003 SHALL hold one circular FIFO per VC, each with read/write pointers (N_BITS_DEPTH) and an occupancy counter (N_BITS_DEPTH+1).
REQ-004 SHALL push in_link_i into VC in_link_i[VC_ID_LSB+:N_BITS_VC] at the clock edge where is_valid_i=1 and that FIFO is not full. A VC id >= N_TOT_OF_VC SHALL be ignored.
REQ-005 SHALL evaluate fullness on the pre-edge occupancy, so a push to a full FIFO is dropped even when a pop occurs on the same VC in the same cycle.
REQ-006 SHALL implement a two-state arbiter, IDLE and LOCKED, with a round-robin pointer rr_r.
REQ-007 In IDLE, SHALL grant the first non-empty VC found scanning from rr_r upward with wrap-around; out_valid_o=1 if any VC is non-empty.
REQ-008 SHALL enter LOCKED when a head flit (type 01) is popped, and SHALL keep the grant on that VC until its tail flit is popped.
REQ-009 In LOCKED, SHALL drive out_valid_o=1 only while the locked VC is non-empty.
REQ-010 A pop SHALL occur when out_valid_o and ready_i are both 1; out_flit_o SHALL be the FIFO head, combinationally from registered storage.
REQ-011 SHALL make a flit pushed at edge t poppable no earlier than cycle t+1.
REQ-012 On popping a tail (10) or head-tail (11) flit: state SHALL return to IDLE, rr_r SHALL be set to (granted VC + 1) mod N_TOT_OF_VC, and free_signal_o[vc] SHALL pulse high for exactly the next cycle.
REQ-013 Every pop SHALL register a one-cycle pulse on credit_signal_o[vc] in the following cycle.
REQ-014 Simultaneous push and pop on the same non-full VC SHALL leave occupancy unchanged.
REQ-015 A body flit popped in IDLE SHALL be delivered without locking, and rr_r SHALL NOT advance.

Reset
REQ-016 On rst=1 at a clock edge, all pointers, counters, rr_r, state (IDLE), credit_signal_o, free_signal_o and overflow_o SHALL go to 0; out_valid_o=0 and out_vc_o=0 in the following cycle.
REQ-017 Flits flushed by reset, including a reset mid-packet, SHALL NOT generate credits or free pulses.

Configuration
REQ-018 With macro FIFO_NOC2NIC_OVF_CHECK_EN defined, a push dropped per REQ-005 or REQ-004 (bad VC id) SHALL set overflow_o=1 until reset.
REQ-019 Without FIFO_NOC2NIC_OVF_CHECK_EN, overflow_o SHALL be tied to 0 and drops SHALL be silent.

Verification
REQ-020 Reset, then push head-tail flit to VC2, ready_i=1 -> out_valid_o=1 with out_vc_o=6'b000100 one cycle later; after the pop, credit_signal_o=6'b000100 and free_signal_o=6'b000100 for one cycle.
REQ-021 Head/body/tail to VC1 interleaved with a head-tail to VC0 -> VC1 stays granted until its tail is popped; rr_r ends at 2; VC0 is served next.
REQ-022 Five pushes to VC3 without pop (depth 4) -> fifth flit dropped, overflow_o=1 with the macro and 0 without it; exactly 4 credits after draining.
REQ-023 VC3 full, then push and pop VC3 in the same cycle -> push dropped, occupancy 3.
REQ-024 Reset asserted with VC4 LOCKED and 2 flits queued -> all outputs 0 the next cycle; no credit or free pulses.
REQ-025 ready_i=0 for 10 cycles with VC5 non-empty -> out_flit_o stable, no credits; the first credit appears the cycle after ready_i rises.
